pulse_seq_axil_regs: RTL

//  AXI4-Lite responder for the pulse_seq peripheral: four 32-bit R/W config registers at 0x0/0x4/0x8/0xC.

---
 rtl/pulse_seq_axil_regs.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pulse_seq_axil_regs.sv
// AXI4-Lite responder for the pulse_seq peripheral: four R/W config registers with byte strobes,
// one outstanding write at a time, and a two-state read channel with registered outputs.
module pulse_seq_axil_regs #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   cfg_regs,
  output logic [3:0]                        cfg_wr_stb
);

  localparam int unsigned DW      = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW      = DW / 8;
  localparam int unsigned NumRegs = 4;

  typedef enum logic {RIdle, RData} r_state_e;

  // Register file
  logic [DW-1:0] regs_q [NumRegs];

  // Write channel state
  logic          rdy_en_q;
  logic          aw_held_q;
  logic          w_held_q;
  logic [1:0]    aw_idx_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;
  logic          bvalid_q;
  logic [3:0]    wr_stb_q;

  // Read channel state
  r_state_e      r_state_q;
  logic          arready_q;
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;

  logic          awready;
  logic          wready;
  logic          commit;
  logic [DW-1:0] wr_mask;
  logic [DW-1:0] wr_merged;

  // rdy_en_q keeps both write READYs low until the first edge after reset is released.
  assign awready = rdy_en_q & ~aw_held_q & ~bvalid_q;
  assign wready  = rdy_en_q & ~w_held_q & ~bvalid_q;
  assign commit  = aw_held_q & w_held_q;

  always_comb begin
    wr_mask = '0;
    for (int unsigned b = 0; b < SW; b++) begin
      wr_mask[8*b +: 8] = {8{wstrb_q[b]}};
    end
    wr_merged = (regs_q[aw_idx_q] & ~wr_mask) | (wdata_q & wr_mask);
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      regs_q[aw_idx_q] <= wr_merged;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rdy_en_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      wr_stb_q  <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      wr_stb_q <= '0;
      if (commit) begin
        wr_stb_q[aw_idx_q] <= 1'b1;
        bvalid_q           <= 1'b1;
        aw_held_q          <= 1'b0;
        w_held_q           <= 1'b0;
      end else begin
        if (S_AXI_AWVALID && awready) begin
          aw_held_q <= 1'b1;
          aw_idx_q  <= S_AXI_AWADDR[3:2];
        end
        if (S_AXI_WVALID && wready) begin
          w_held_q <= 1'b1;
          wdata_q  <= S_AXI_WDATA;
          wstrb_q  <= S_AXI_WSTRB;
        end
      end
      // Commit never coincides with an open response: READYs are low while BVALID is set.
      if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read channel; regs_q is sampled before any same-edge commit lands.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state_q <= RIdle;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      unique case (r_state_q)
        RIdle: begin
          if (!arready_q) begin
            arready_q <= 1'b1;
          end else if (S_AXI_ARVALID) begin
            rdata_q   <= regs_q[S_AXI_ARADDR[3:2]];
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            r_state_q <= RData;
          end
        end
        RData: begin
          if (S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= RIdle;
          end
        end
      endcase
    end
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign cfg_regs      = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};
  assign cfg_wr_stb    = wr_stb_q;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule
